pc: RTL and testbench



---
 rtl/pc.sv | 58 +++++
 tb/tb_pc.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pc.sv
// pc -- fetch-stage program-counter register.
//
// Holds the address of the instruction being fetched. The next-PC value
// chosen upstream is loaded on every rising edge unless the hazard unit
// stalls the fetch stage. The sequential address and an alignment flag
// are derived combinationally from the stored PC.
//
// Parameters:
//   WIDTH         address width in bits (must be at least 2)
//   RESET_VECTOR  value loaded by reset
//
// Ports:
//   clk            system clock, all state updates on the rising edge
//   rst_n          synchronous active-low reset (highest priority)
//   PC_Enable      1 = load PC_Input, 0 = hold (stall)
//   PC_Input       next-PC value from the next-PC mux
//   PC_Output      current PC, registered
//   PC_Plus4       PC_Output + 4, modulo 2^WIDTH
//   PC_Misaligned  1 when PC_Output[1:0] != 2'b00
module pc #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PC_Enable,
    input  logic [WIDTH-1:0] PC_Input,
    output logic [WIDTH-1:0] PC_Output,
    output logic [WIDTH-1:0] PC_Plus4,
    output logic             PC_Misaligned
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    // Next-state: load on enable, otherwise hold. Reset is applied in the
    // register block so it overrides the enable.
    always_comb begin
        pc_d = pc_q;
        if (PC_Enable) begin
            pc_d = PC_Input;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC_Output     = pc_q;
    // Carry out of the top bit is discarded, so the address wraps.
    assign PC_Plus4      = pc_q + WIDTH'(4);
    assign PC_Misaligned = |pc_q[1:0];

endmodule

// File: tb/tb_pc.sv
module tb_pc;

    localparam int unsigned WIDTH = 32;
    localparam logic [31:0] RV    = 32'h0000_0000;

    logic             clk;
    logic             rst_n;
    logic             PC_Enable;
    logic [WIDTH-1:0] PC_Input;
    logic [WIDTH-1:0] PC_Output;
    logic [WIDTH-1:0] PC_Plus4;
    logic             PC_Misaligned;

    pc #(.WIDTH(WIDTH), .RESET_VECTOR(RV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PC_Enable    (PC_Enable),
        .PC_Input     (PC_Input),
        .PC_Output    (PC_Output),
        .PC_Plus4     (PC_Plus4),
        .PC_Misaligned(PC_Misaligned)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        bit          known;
        logic [31:0] pc;
        logic [31:0] plus4;
        bit          mis;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: the architectural PC value as seen after each edge.
    bit          model_known = 0;
    longint      model_pc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Advance the model over one edge with the inputs that will be sampled
    // there, and queue the response expected after that edge.
    task automatic push_expect(input bit r, input bit en, input logic [31:0] din);
        exp_t e;
        if (!r) begin
            model_pc    = RV;
            model_known = 1;
        end else if (en) begin
            model_pc    = din;
            model_known = 1;
        end
        e.known = model_known;
        e.pc    = 32'(model_pc);
        e.plus4 = 32'((model_pc + 4) % 64'h1_0000_0000);
        e.mis   = (model_pc % 4) != 0;
        q.push_back(e);
    endtask

    task automatic step(input bit r, input bit en, input logic [31:0] din);
        @(negedge clk);
        rst_n     = r;
        PC_Enable = en;
        PC_Input  = din;
        push_expect(r, en, din);
    endtask

    // Monitor: pops one expectation shortly after each rising edge, then
    // confirms the output has not moved late in the same cycle.
    initial begin : monitor
        exp_t held;
        held.known = 0;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                held = q.pop_front();
                if (held.known) begin
                    chk("pc_out", PC_Output, held.pc);
                    chk("pc_plus4", PC_Plus4, held.plus4);
                    chk("misaligned", {31'b0, PC_Misaligned}, {31'b0, held.mis});
                end
            end
            #16;
            if (held.known) chk("pc_hold_midcycle", PC_Output, held.pc);
        end
    end

    initial begin : stimulus
        int unsigned n;
        rst_n     = 1'b1;
        PC_Enable = 1'b0;
        PC_Input  = '0;

        // Reset overrides a pending load.
        step(0, 1, 32'h1234_5678);

        // Sequential load with PC_Input changing every 4 time units; the
        // value present at the edge (set at negedge+9) is the one loaded.
        n = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rst_n = 1; PC_Enable = 1;
            #1 PC_Input = n % 10; n++;
            #4 PC_Input = n % 10; n++;
            #4 PC_Input = n % 10; push_expect(1, 1, n % 10); n++;
            #4 PC_Input = n % 10; n++;
            #4 PC_Input = n % 10; n++;
        end

        // Stall.
        step(1, 1, 32'h0000_0100);
        for (int i = 0; i < 3; i++) step(1, 0, 32'h0000_0200);
        step(1, 1, 32'h0000_0200);

        // Reset priority mid-stream.
        step(1, 1, 32'h0000_0040);
        step(0, 1, 32'hDEAD_BEEC);
        step(1, 1, 32'hDEAD_BEEC);

        // Wrap and misalignment.
        step(1, 1, 32'hFFFF_FFFC);
        step(1, 1, 32'h0000_0006);
        step(1, 0, 32'h0000_0008);
        step(1, 1, 32'hFFFF_FFFF);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] d;
            d = $urandom;
            if ($urandom_range(0, 1) == 0) d[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) d = 32'hFFFF_FFFC;
            step($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0, d);
        end

        // Drain: every queued expectation must be consumed within a bound.
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
